// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, read-pointer synchronizer and fill flags for an async FIFO
module fifo_wr_ctrl #(
    parameter int ADD_WIDTH    = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = (1 << ADD_WIDTH) - 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic                 ovf_clr,
    input  logic [ADD_WIDTH:0]   rd_gry_async,
    output logic [ADD_WIDTH-1:0] wr_addrs,
    output logic [ADD_WIDTH:0]   wr_ptr_gry,
    output logic                 wr_ack,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic [ADD_WIDTH:0]   wr_level,
    output logic                 overflow
);
    localparam logic [ADD_WIDTH:0] DEPTH_L = (ADD_WIDTH+1)'(1 << ADD_WIDTH);
    localparam logic [ADD_WIDTH:0] AFULL_L = (ADD_WIDTH+1)'(AFULL_THRESH);
    logic [SYNC_STAGES-1:0][ADD_WIDTH:0] sync_q, sync_d;
    logic [ADD_WIDTH:0] rd_gry_sync, rd_bin;
    logic [ADD_WIDTH:0] wr_ptr_bin_q, wr_ptr_bin_d, wr_ptr_gry_q, wr_ptr_gry_d;
    logic               ovf_q, ovf_d, push;
    assign sync_d      = {sync_q[SYNC_STAGES-2:0], rd_gry_async};
    assign rd_gry_sync = sync_q[SYNC_STAGES-1];
    // each binary bit is the XOR of its Gray bit and every Gray bit above it
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= ADD_WIDTH; i++) rd_bin[i] = ^(rd_gry_sync >> i);
    end
    assign wr_level    = wr_ptr_bin_q - rd_bin;
    assign fifo_full   = wr_level == DEPTH_L;
    assign almost_full = wr_level >= AFULL_L;
    assign push        = wr_rst & wr_en & ~fifo_full;
    assign wr_ack      = push;
    assign wr_ptr_bin_d = wr_ptr_bin_q + (ADD_WIDTH+1)'(push);
    assign wr_ptr_gry_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
    // a rejected write outranks a simultaneous clear
    assign ovf_d = (wr_en & fifo_full) | (ovf_q & ~ovf_clr);
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            sync_q       <= '0;
            wr_ptr_bin_q <= '0;
            wr_ptr_gry_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            wr_ptr_bin_q <= wr_ptr_bin_d;
            wr_ptr_gry_q <= wr_ptr_gry_d;
            ovf_q        <= ovf_d;
        end
    end
    assign wr_addrs   = wr_ptr_bin_q[ADD_WIDTH-1:0];
    assign wr_ptr_gry = wr_ptr_gry_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: vector table plus scoreboard checks for the FIFO write controller
module tb_fifo_wr_ctrl;
    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] rd;
        logic       ack;
        logic [2:0] addr;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
        logic [3:0] gry;
    } vec_t;

    logic       wr_clk = 1'b0;
    logic       wr_rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] rd_gry_async = '0;
    logic [2:0] wr_addrs;
    logic [3:0] wr_ptr_gry;
    logic       wr_ack, fifo_full, almost_full, overflow;
    logic [3:0] wr_level;
    int         n_chk = 0;
    int         n_err = 0;
    vec_t       tbl[12];
    vec_t       sbq[$];
    vec_t       e;
    logic [3:0] prev;

    fifo_wr_ctrl #(.ADD_WIDTH(3), .SYNC_STAGES(2), .AFULL_THRESH(6)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .ovf_clr(ovf_clr),
        .rd_gry_async(rd_gry_async), .wr_addrs(wr_addrs), .wr_ptr_gry(wr_ptr_gry),
        .wr_ack(wr_ack), .fifo_full(fifo_full), .almost_full(almost_full),
        .wr_level(wr_level), .overflow(overflow)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic vec_t mk(input logic en, input logic clr, input logic [3:0] rd,
                                input logic ack, input logic [2:0] addr, input logic [3:0] lvl,
                                input logic full, input logic af, input logic ovf,
                                input logic [3:0] gry);
        vec_t v;
        v.en = en; v.clr = clr; v.rd = rd; v.ack = ack; v.addr = addr;
        v.lvl = lvl; v.full = full; v.af = af; v.ovf = ovf; v.gry = gry;
        return v;
    endfunction

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic post_chk(input vec_t x);
        chk("level", 32'(wr_level), 32'(x.lvl));
        chk("full", 32'(fifo_full), 32'(x.full));
        chk("afull", 32'(almost_full), 32'(x.af));
        chk("ovf", 32'(overflow), 32'(x.ovf));
        chk("gry", 32'(wr_ptr_gry), 32'(x.gry));
    endtask

    task automatic apply(input vec_t v);
        vec_t x;
        @(negedge wr_clk);
        wr_en = v.en; ovf_clr = v.clr; rd_gry_async = v.rd;
        #1;
        chk("ack", 32'(wr_ack), 32'(v.ack));
        chk("addr", 32'(wr_addrs), 32'(v.addr));
        sbq.push_back(v);
        @(posedge wr_clk);
        #1;
        x = sbq.pop_front();
        post_chk(x);
    endtask

    task automatic zero_chk(input string nm);
        chk({nm, "_addr"}, 32'(wr_addrs), 0);
        chk({nm, "_gry"}, 32'(wr_ptr_gry), 0);
        chk({nm, "_ack"}, 32'(wr_ack), 0);
        chk({nm, "_full"}, 32'(fifo_full), 0);
        chk({nm, "_afull"}, 32'(almost_full), 0);
        chk({nm, "_level"}, 32'(wr_level), 0);
        chk({nm, "_ovf"}, 32'(overflow), 0);
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        #2;
        wr_en = 1'b1; ovf_clr = 1'b0; rd_gry_async = '0; wr_rst = 1'b0;
        #1;
        zero_chk("rst");
        repeat (2) @(posedge wr_clk);
        #1;
        zero_chk("rst_hold");
        @(negedge wr_clk);
        wr_rst = 1'b1; wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0001);
        tbl[1]  = mk(1, 0, 0, 1, 1, 2, 0, 0, 0, 4'b0011);
        tbl[2]  = mk(1, 0, 0, 1, 2, 3, 0, 0, 0, 4'b0010);
        tbl[3]  = mk(1, 0, 0, 1, 3, 4, 0, 0, 0, 4'b0110);
        tbl[4]  = mk(1, 0, 0, 1, 4, 5, 0, 0, 0, 4'b0111);
        tbl[5]  = mk(1, 0, 0, 1, 5, 6, 0, 1, 0, 4'b0101);
        tbl[6]  = mk(1, 0, 0, 1, 6, 7, 0, 1, 0, 4'b0100);
        tbl[7]  = mk(1, 0, 0, 1, 7, 8, 1, 1, 0, 4'b1100);
        tbl[8]  = mk(1, 0, 0, 0, 0, 8, 1, 1, 1, 4'b1100);
        tbl[9]  = mk(0, 1, 0, 0, 0, 8, 1, 1, 0, 4'b1100);
        tbl[10] = mk(1, 1, 0, 0, 0, 8, 1, 1, 1, 4'b1100);
        tbl[11] = mk(0, 1, 0, 0, 0, 8, 1, 1, 0, 4'b1100);

        do_reset();
        for (int i = 0; i < 12; i++) apply(tbl[i]);

        // read pointer moves by one entry while full: two-edge synchronizer lag
        @(negedge wr_clk);
        wr_en = 1'b0; ovf_clr = 1'b0; rd_gry_async = 4'b0001;
        @(posedge wr_clk);
        #1;
        chk("sync1_full", 32'(fifo_full), 1);
        chk("sync1_level", 32'(wr_level), 8);
        @(posedge wr_clk);
        #1;
        chk("sync2_full", 32'(fifo_full), 0);
        chk("sync2_level", 32'(wr_level), 7);
        chk("sync2_afull", 32'(almost_full), 1);

        // reader tracks the writer through a full pointer wrap
        do_reset();
        prev = 4'b0000;
        for (int j = 0; j < 16; j++) begin
            @(negedge wr_clk);
            wr_en = 1'b1; rd_gry_async = gray(4'(j));
            #1;
            chk("trk_ack", 32'(wr_ack), 1);
            sbq.push_back(mk(1, 0, gray(4'(j)), 1, 3'(j), (j == 0) ? 4'd1 : 4'd2, 0, 0, 0,
                             gray(4'(j + 1))));
            @(posedge wr_clk);
            #1;
            e = sbq.pop_front();
            chk("trk_gry", 32'(wr_ptr_gry), 32'(e.gry));
            chk("trk_level", 32'(wr_level), 32'(e.lvl));
            chk("trk_onebit", 32'($countones(prev ^ wr_ptr_gry)), 1);
            chk("trk_lvl_max", 32'(wr_level <= 4'd8), 1);
            prev = wr_ptr_gry;
        end

        // mid-operation reset at level 5
        do_reset();
        for (int k = 0; k < 5; k++)
            apply(mk(1, 0, 0, 1, 3'(k), 4'(k + 1), 0, 0, 0, gray(4'(k + 1))));
        @(posedge wr_clk);
        #3;
        wr_en = 1'b1; wr_rst = 1'b0;
        #1;
        zero_chk("midrst");
        #1;
        wr_rst = 1'b1; wr_en = 1'b0;
        apply(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0001));
        chk("post_rst_addr", 32'(wr_addrs), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
